ahb_sram_slave: RTL and testbench
=================================

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001: Parameter ADDR_W, default 8, word-address bits; memory depth is 2**ADDR_W 32-bit words.
REQ-002: Parameter WAIT_STATES, default 1, range 0..15; number of HREADYOUT-low cycles inserted in every OKAY data phase.
REQ-003: HCLK  input  1  sole clock; all state changes on the rising edge.
REQ-004: HRESETn  input  1  asynchronous, active-low reset.
REQ-005: HSEL  input  1  slave select.
REQ-006: HADDR  input  32  byte address.
REQ-007: HTRANS  input  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008: HWRITE  input  1  1 = write, 0 = read.
REQ-009: HSIZE  input  3  000 = byte, 001 = halfword, 010 = word; all other codes are illegal.
REQ-010: HWDATA  input  32  write data, valid in the data phase.
REQ-011: HREADY  input  1  bus-level ready; an address phase is sampled only when HREADY=1.
REQ-012: HRDATA  output  32  read data.
REQ-013: HREADYOUT  output  1  slave ready.
REQ-014: HRESP  output  1  0 = OKAY, 1 = ERROR.

Function
REQ-015: An address phase is accepted on a rising edge when HSEL=1, HTRANS[1]=1 and HREADY=1; HADDR, HWRITE and HSIZE are registered at that edge.
REQ-016: IDLE or BUSY transfers, and cycles with HSEL=0, get a zero-wait OKAY response (HREADYOUT=1, HRESP=0) and do not change memory.
REQ-017: An accepted transfer is an error in any of these cases: HADDR[31:ADDR_W+2] is non-zero; HSIZE=001 with HADDR[0]=1; HSIZE=010 with HADDR[1:0] not 00; HSIZE is above 010.
REQ-018: The state machine has four states: IDLE, WAIT, ERR1 and ERR2; the encoding is an enum in the shared package.
REQ-019: IDLE goes to WAIT on an accepted legal transfer when WAIT_STATES>0.
REQ-020: IDLE stays in IDLE on an accepted legal transfer when WAIT_STATES=0; the data phase is the next cycle with HREADYOUT=1.
REQ-021: IDLE goes to ERR1 on an accepted illegal transfer.
REQ-022: In WAIT, a down-counter loaded with WAIT_STATES holds HREADYOUT=0; when the counter reaches 0, HREADYOUT=1 for one cycle and the state returns to IDLE.
REQ-023: ERR1 drives HRESP=1 and HREADYOUT=0 for one cycle, then goes to ERR2.
REQ-024: ERR2 drives HRESP=1 and HREADYOUT=1 for one cycle, then goes to IDLE; a new transfer may be accepted in the ERR2 cycle.
REQ-025: A new address phase presented during the completing data-phase cycle (HREADYOUT=1) is accepted, so transfers pipeline back-to-back with no idle cycle.
REQ-026: A write is committed at the edge that ends its OKAY data phase, using the byte lanes selected by HSIZE and HADDR[1:0] (little-endian); an errored write never changes memory.
REQ-027: HRDATA is the full 32-bit word at the registered address during a read OKAY data phase; it is 0 at all other times.
REQ-028: A read whose address phase overlaps the data phase of a write to the same word returns the newly written data.

Reset
REQ-029: Asserting HRESETn low at any time, including mid-wait or mid-error, forces state=IDLE, the counter to 0, HREADYOUT=1, HRESP=0 and HRDATA=0.
REQ-030: Memory contents are not cleared by reset; a write that has not committed when reset asserts is discarded.

Structure
REQ-031: Package ahb_pkg holds the HTRANS, HSIZE and HRESP encodings and the state enum.
REQ-032: Sub-module ahb_sram_array holds the storage: 2**ADDR_W x 32 bits, synchronous write with 4-bit byte enables, asynchronous read.

Verification
REQ-033: WAIT_STATES=1; word write of 0xDEADBEEF to 0x10, then a read of 0x10 -> one HREADYOUT-low cycle per transfer; read returns 0xDEADBEEF with HRESP=0.
REQ-034: Byte write of 0xAB to 0x13 over the word 0x11223344 at 0x10 -> reading 0x10 returns 0xAB223344.
REQ-035: Word read at 0x02 -> HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1; memory is unchanged.
REQ-036: ADDR_W=8; read at 0x400 -> two-cycle ERROR response; HRDATA=0.
REQ-037: WAIT_STATES=0; write 0x5 to 0x20 immediately followed by a read of 0x20 -> read data phase returns 0x5 with no stall cycles.
REQ-038: Assert HRESETn low during the WAIT of a write of 0x77 to 0x30 -> HREADYOUT=1 and HRESP=0 immediately; a later read of 0x30 returns its old value.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings, controller state enum and the byte-lane helper used
// by the SRAM slave.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Little-endian lane enables; only called for sizes already checked legal.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] a);
    case (size)
      HSIZE_BYTE: byte_en = 4'b0001 << a;
      HSIZE_HALF: byte_en = a[1] ? 4'b1100 : 4'b0011;
      default:    byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-wide storage with per-byte write enables and asynchronous read.
// Not reset: contents survive HRESETn.
module ahb_sram_array #(
  parameter int ADDR_W = 8
) (
  input  logic              HCLK,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge HCLK) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: programmable wait states, two-cycle ERROR response for
// out-of-range or misaligned transfers, writes committed at data-phase end.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  state_t            state;
  logic [3:0]        cnt;
  logic              dp_q;
  logic              write_q;
  logic              hrdy_q;
  hresp_t            hresp_q;
  logic [ADDR_W+1:0] addr_q;
  logic [2:0]        size_q;
  logic [31:0]       rdata;
  htrans_t           htrans;
  logic              accept;
  logic              illegal;
  logic              commit;

  assign htrans  = htrans_t'(HTRANS);
  // hrdy_q guard keeps a stray HREADY from starting a transfer mid-stall.
  assign accept  = HSEL && HREADY && hrdy_q &&
                   (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
  assign illegal = (|(HADDR >> (ADDR_W + 2))) ||
                   (HSIZE == HSIZE_HALF && HADDR[0]) ||
                   (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00) ||
                   (HSIZE > HSIZE_WORD);

  // dp_q marks an OKAY data phase in flight; it ends on the first ready cycle.
  assign commit = dp_q && hrdy_q && write_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      dp_q    <= 1'b0;
      write_q <= 1'b0;
      hrdy_q  <= 1'b1;
      hresp_q <= HRESP_OKAY;
      addr_q  <= '0;
      size_q  <= '0;
    end else if (!hrdy_q) begin
      if (state == ST_ERR1) begin
        state  <= ST_ERR2;
        hrdy_q <= 1'b1;
      end else begin
        cnt    <= cnt - 4'd1;
        hrdy_q <= (cnt == 4'd1);
      end
    end else if (accept) begin
      addr_q  <= HADDR[ADDR_W+1:0];
      write_q <= HWRITE;
      size_q  <= HSIZE;
      if (illegal) begin
        state   <= ST_ERR1;
        hrdy_q  <= 1'b0;
        hresp_q <= HRESP_ERROR;
        dp_q    <= 1'b0;
      end else if (WAIT_STATES > 0) begin
        state   <= ST_WAIT;
        cnt     <= 4'(WAIT_STATES);
        hrdy_q  <= 1'b0;
        hresp_q <= HRESP_OKAY;
        dp_q    <= 1'b1;
      end else begin
        state   <= ST_IDLE;
        hresp_q <= HRESP_OKAY;
        dp_q    <= 1'b1;
      end
    end else begin
      state   <= ST_IDLE;
      hresp_q <= HRESP_OKAY;
      dp_q    <= 1'b0;
    end
  end

  ahb_sram_array #(.ADDR_W(ADDR_W)) u_array (
    .HCLK  (HCLK),
    .we    (commit),
    .be    (byte_en(size_q, addr_q[1:0])),
    .addr  (addr_q[ADDR_W+1:2]),
    .wdata (HWDATA),
    .rdata (rdata)
  );

  assign HRDATA    = (dp_q && !write_q) ? rdata : 32'h0;
  assign HREADYOUT = hrdy_q;
  assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboarded bench for two slave configurations (one and zero wait states);
// the driver queues expected responses and a negedge monitor retires them.
module tb_ahb_sram_slave;

  logic        HCLK;
  logic        HRESETn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        sel;

  logic [31:0] hrdata1, hrdata0;
  logic        ho1, ho0, hresp1, hresp0;
  logic        m_rdy, m_resp;
  logic [31:0] m_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          st;
    string       nm;
  } exp_t;
  exp_t q[$];

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_sram_slave #(.ADDR_W(8), .WAIT_STATES(1)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel && !sel), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
    .HREADY(ho1), .HRDATA(hrdata1), .HREADYOUT(ho1), .HRESP(hresp1)
  );

  ahb_sram_slave #(.ADDR_W(8), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel && sel), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
    .HREADY(ho0), .HRDATA(hrdata0), .HREADYOUT(ho0), .HRESP(hresp0)
  );

  assign m_rdy   = sel ? ho0     : ho1;
  assign m_resp  = sel ? hresp0  : hresp1;
  assign m_rdata = sel ? hrdata0 : hrdata1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: finish the current data phase first, then note a new acceptance.
  initial begin : monitor
    logic active;
    logic low_bad;
    int   stalls;
    exp_t e;
    active = 1'b0; low_bad = 1'b0; stalls = 0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        active = 1'b0;
        q.delete();
      end else begin
        if (active && q.size() > 0) begin
          if (!m_rdy) begin
            stalls++;
            if (m_resp !== q[0].err) low_bad = 1'b1;
          end else begin
            e = q.pop_front();
            chk({e.nm, " resp"}, {31'b0, m_resp}, {31'b0, e.err});
            chk({e.nm, " rdata"}, m_rdata, e.rd);
            chk({e.nm, " stalls"}, stalls, e.st);
            chk({e.nm, " lowresp"}, {31'b0, low_bad}, 32'd0);
            active = 1'b0;
          end
        end
        if (hsel && htrans[1] && m_rdy) begin
          active = 1'b1; stalls = 0; low_bad = 1'b0;
        end
      end
    end
  end

  task automatic addr_phase(input logic w, input logic [31:0] a, input logic [2:0] sz);
    logic r;
    int   n;
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz;
    n = 0;
    do begin
      @(negedge HCLK); r = m_rdy;
      @(posedge HCLK); #1; n++;
    end while (!r && n < 50);
    if (!r) begin
      total++; bad++;
      $display("FAIL accept %h: got no ready within 50 cycles expected ready", a);
    end
    hsel = 1'b0; htrans = 2'b00;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, input logic [31:0] rd, input logic err,
                       input int st, input string nm);
    exp_t e;
    e.rd = rd; e.err = err; e.st = st; e.nm = nm;
    q.push_back(e);
    addr_phase(w, a, sz);
    hwdata = wd;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge HCLK); #1; end
  endtask

  initial begin
    HRESETn = 1'b0; sel = 1'b0;
    hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010; hwdata = '0;
    #12;
    chk("rst ready1", {31'b0, ho1}, 32'd1);
    chk("rst resp1",  {31'b0, hresp1}, 32'd0);
    chk("rst rdata1", hrdata1, 32'd0);
    chk("rst ready0", {31'b0, ho0}, 32'd1);
    chk("rst resp0",  {31'b0, hresp0}, 32'd0);
    chk("rst rdata0", hrdata0, 32'd0);
    @(posedge HCLK); #1; HRESETn = 1'b1;
    idle(2);

    // one wait state
    issue(1, 32'h10,  3'b010, 32'hDEADBEEF, 32'h0,        0, 1, "wr10");
    issue(0, 32'h10,  3'b010, 32'h0,        32'hDEADBEEF, 0, 1, "rd10");
    issue(1, 32'h10,  3'b010, 32'h11223344, 32'h0,        0, 1, "wr10b");
    issue(1, 32'h13,  3'b000, 32'hAB000000, 32'h0,        0, 1, "wrb13");
    issue(0, 32'h10,  3'b010, 32'h0,        32'hAB223344, 0, 1, "rd10b");
    issue(1, 32'h00,  3'b010, 32'h0BADF00D, 32'h0,        0, 1, "wr00");
    issue(0, 32'h02,  3'b010, 32'h0,        32'h0,        1, 1, "rd02err");
    issue(1, 32'h02,  3'b010, 32'hFFFFFFFF, 32'h0,        1, 1, "wr02err");
    issue(0, 32'h00,  3'b010, 32'h0,        32'h0BADF00D, 0, 1, "rd00");
    issue(0, 32'h400, 3'b010, 32'h0,        32'h0,        1, 1, "rd400err");
    issue(1, 32'h400, 3'b010, 32'hCAFEF00D, 32'h0,        1, 1, "wr400err");
    issue(0, 32'h00,  3'b010, 32'h0,        32'h0BADF00D, 0, 1, "rd00b");
    issue(1, 32'h12,  3'b001, 32'hBEEF0000, 32'h0,        0, 1, "wrh12");
    issue(1, 32'h11,  3'b001, 32'h12345678, 32'h0,        1, 1, "wrh11err");
    issue(1, 32'h10,  3'b011, 32'h12345678, 32'h0,        1, 1, "wrsz3err");
    issue(0, 32'h10,  3'b010, 32'h0,        32'hBEEF3344, 0, 1, "rd10c");
    issue(1, 32'h30,  3'b010, 32'h00000055, 32'h0,        0, 1, "wr30");

    // reset lands inside the wait cycle of a write that must be dropped
    addr_phase(1, 32'h30, 3'b010);
    hwdata = 32'h77;
    #2 HRESETn = 1'b0;
    #1;
    chk("midrst ready", {31'b0, ho1}, 32'd1);
    chk("midrst resp",  {31'b0, hresp1}, 32'd0);
    chk("midrst rdata", hrdata1, 32'd0);
    @(posedge HCLK); #1; HRESETn = 1'b1;
    idle(1);
    issue(0, 32'h30, 3'b010, 32'h0, 32'h00000055, 0, 1, "rd30");
    idle(4);

    // zero wait states
    sel = 1'b1;
    idle(1);
    issue(1, 32'h20,  3'b010, 32'h5, 32'h0, 0, 0, "z_wr20");
    issue(0, 32'h20,  3'b010, 32'h0, 32'h5, 0, 0, "z_rd20");
    issue(0, 32'h400, 3'b010, 32'h0, 32'h0, 1, 1, "z_rd400err");
    issue(1, 32'h21,  3'b000, 32'h0000A600, 32'h0, 0, 0, "z_wrb21");
    issue(0, 32'h20,  3'b010, 32'h0, 32'h0000A605, 0, 0, "z_rd20b");

    begin : drain
      int n;
      n = 0;
      while (q.size() > 0 && n < 100) begin @(posedge HCLK); n++; end
      if (q.size() > 0) begin
        total++; bad++;
        $display("FAIL drain: got %0d pending expected 0", q.size());
      end
    end
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
